// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch front end.
//   XLEN_DEF  : default address/PC width
//   NOP_INSTR : canonical RV32 NOP (addi x0,x0,0)
//   PC_INCR   : sequential fetch stride in bytes
//   clog2()   : ceiling log2, used to size occupancy and pointer fields
package fetch_pkg;

  localparam int unsigned XLEN_DEF  = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam int unsigned PC_INCR   = 4;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'(1) << i) < 64'(value)) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through synchronous FIFO.
// The head entry is always presented on head_data while head_valid is high;
// a pushed entry becomes visible on the cycle after the push.
//   clk, rst       : clock, asynchronous active-low reset
//   push/push_data : write an entry (ignored when full unless popping)
//   pop            : remove the head entry (ignored when empty)
//   flush          : discard all entries; wins over push and pop
//   head_data      : current head entry
//   head_valid     : FIFO not empty
//   occupancy      : number of stored entries (0..DEPTH)
module sync_fifo_fwft
  import fetch_pkg::*;
#(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [WIDTH-1:0]      push_data,
  input  logic                  pop,
  input  logic                  flush,
  output logic [WIDTH-1:0]      head_data,
  output logic                  head_valid,
  output logic [clog2(DEPTH):0] occupancy
);

  localparam int unsigned AW = clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop && (count != '0);
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_push = push && ((count != (AW+1)'(DEPTH)) || do_pop);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  assign head_data  = mem[rd_ptr];
  assign head_valid = (count != '0);
  assign occupancy  = count;

endmodule

// File: rtl/if_prefetch_queue.sv
// Instruction-fetch front end: issues in-order requests to instruction memory
// and buffers returned {pc, instr} pairs for decode.
//   clk, rst        : clock, asynchronous active-low reset
//   redirect_valid  : flush queue and refetch from redirect_pc (word aligned)
//   imem_req_*      : fetch request channel (valid/ready, word address)
//   imem_rsp_*      : in-order responses, one instruction per valid cycle
//   out_*           : queue head to decode (valid/ready), pc, pc+4, instr
//   occupancy       : current queue entries
module if_prefetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned     XLEN            = XLEN_DEF,
  parameter int unsigned     DEPTH           = 4,
  parameter int unsigned     MAX_OUTSTANDING = 2,
  parameter logic [XLEN-1:0] RESET_PC        = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  redirect_valid,
  input  logic [XLEN-1:0]       redirect_pc,
  output logic                  imem_req_valid,
  input  logic                  imem_req_ready,
  output logic [XLEN-1:0]       imem_req_addr,
  input  logic                  imem_rsp_valid,
  input  logic [31:0]           imem_rsp_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [XLEN-1:0]       out_pc,
  output logic [XLEN-1:0]       out_pc_plus4,
  output logic [31:0]           out_instr,
  output logic [clog2(DEPTH):0] occupancy
);

  localparam int unsigned CW = clog2(DEPTH) + 1;
  localparam int unsigned SW = CW + 1;

  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] rsp_pc;
  logic [XLEN-1:0] redirect_base;
  logic [CW-1:0]   live, live_next;
  logic [CW-1:0]   stale, stale_next;
  logic [SW-1:0]   in_flight;
  logic [SW-1:0]   credit_use;
  logic            req_fire;
  logic            rsp_ok;
  logic            q_push;
  logic            q_pop;

  assign redirect_base = {redirect_pc[XLEN-1:2], 2'b00};
  assign in_flight     = SW'(live) + SW'(stale);
  assign credit_use    = SW'(occupancy) + SW'(live);

  // Every live request owns a queue slot, so responses are never refused.
  assign imem_req_valid = rst && !redirect_valid
                       && (in_flight  < SW'(MAX_OUTSTANDING))
                       && (credit_use < SW'(DEPTH));
  assign imem_req_addr  = fetch_pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // A response with nothing outstanding is a protocol error and is ignored.
  assign rsp_ok = imem_rsp_valid && (in_flight != '0);
  assign q_push = rsp_ok && (stale == '0) && !redirect_valid;
  assign q_pop  = out_valid && out_ready && !redirect_valid;

  always_comb begin
    live_next  = live;
    stale_next = stale;
    if (redirect_valid) begin
      // Everything still outstanding becomes stale, minus the response
      // retiring this very cycle.
      live_next  = '0;
      stale_next = stale + live - CW'(rsp_ok);
    end else begin
      if (req_fire) live_next = live_next + CW'(1);
      if (q_push)   live_next = live_next - CW'(1);
      if (rsp_ok && (stale != '0)) stale_next = stale - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc <= RESET_PC;
      rsp_pc   <= RESET_PC;
      live     <= '0;
      stale    <= '0;
    end else begin
      live  <= live_next;
      stale <= stale_next;
      if (redirect_valid) begin
        fetch_pc <= redirect_base;
        rsp_pc   <= redirect_base;
      end else begin
        if (req_fire) fetch_pc <= fetch_pc + XLEN'(PC_INCR);
        if (q_push)   rsp_pc   <= rsp_pc   + XLEN'(PC_INCR);
      end
    end
  end

  sync_fifo_fwft #(
    .WIDTH (XLEN + 32),
    .DEPTH (DEPTH)
  ) u_queue (
    .clk        (clk),
    .rst        (rst),
    .push       (q_push),
    .push_data  ({rsp_pc, imem_rsp_data}),
    .pop        (q_pop),
    .flush      (redirect_valid),
    .head_data  ({out_pc, out_instr}),
    .head_valid (out_valid),
    .occupancy  (occupancy)
  );

  assign out_pc_plus4 = out_pc + XLEN'(PC_INCR);

  rsp_expected_a: assert property (@(posedge clk) disable iff (!rst)
    imem_rsp_valid |-> (in_flight != '0));

  credit_bound_a: assert property (@(posedge clk) disable iff (!rst)
    in_flight <= SW'(MAX_OUTSTANDING));

endmodule

// File: tb/tb_if_prefetch_queue.sv
module tb_if_prefetch_queue;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned MAXO  = 2;
  localparam logic [31:0] RPC   = 32'h0000_0000;
  localparam logic [31:0] KEY   = 32'hA5A5_0000;

  logic            clk;
  logic            rst;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  logic [31:0]     imem_rsp_data;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [XLEN-1:0] out_pc_plus4;
  logic [31:0]     out_instr;
  logic [2:0]      occupancy;

  if_prefetch_queue #(
    .XLEN            (XLEN),
    .DEPTH           (DEPTH),
    .MAX_OUTSTANDING (MAXO),
    .RESET_PC        (RPC)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_pc_plus4   (out_pc_plus4),
    .out_instr      (out_instr),
    .occupancy      (occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: outstanding requests in order, each tagged live/stale.
  typedef struct {
    logic [31:0] addr;
    bit          live;
    int          due;
  } req_t;
  // Scoreboard: instructions decode should see, in order.
  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  req_t        infl[$];
  exp_t        expq[$];
  int          tests, fails;
  int          cycle, last_due, occ_model;
  logic [31:0] fetch_model;
  int          lat_min, lat_max, p_rdy, p_out, p_redir;
  int          win_lo, win_hi, pop_cnt, first_rsp, first_out;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, want, cycle);
    end
  endtask

  // Monitor: every instruction handed to decode must match the scoreboard head.
  exp_t mon_e;
  always @(negedge clk) begin
    if (rst && out_valid && out_ready && !redirect_valid) begin
      if (expq.size() == 0) begin
        check("unexpected_out", 32'd1, 32'd0);
      end else begin
        mon_e = expq.pop_front();
        check("out_pc", out_pc, mon_e.pc);
        check("out_instr", out_instr, mon_e.instr);
        check("out_pc_plus4", out_pc_plus4, mon_e.pc + 32'd4);
      end
    end
  end

  task automatic drive_inputs();
    imem_rsp_valid = (infl.size() > 0) && (infl[0].due <= cycle);
    imem_rsp_data  = imem_rsp_valid ? (infl[0].addr ^ KEY) : $urandom;
    imem_req_ready = ($urandom_range(99) < p_rdy);
    out_ready      = ($urandom_range(99) < p_out);
    redirect_valid = ($urandom_range(99) < p_redir);
    redirect_pc    = $urandom;
  endtask

  task automatic step();
    bit   hs, rv, redir, pop, want_valid;
    int   live_cnt, lat, due;
    req_t r;
    @(negedge clk);
    hs    = imem_req_valid && imem_req_ready;
    rv    = imem_rsp_valid;
    redir = redirect_valid;
    pop   = out_valid && out_ready && !redir;
    live_cnt = 0;
    foreach (infl[i]) if (infl[i].live) live_cnt++;
    want_valid = !redir && (infl.size() < MAXO) && (occ_model + live_cnt < DEPTH);
    check("occupancy", 32'(occupancy), 32'(occ_model));
    check("out_valid", 32'(out_valid), 32'(occ_model != 0));
    check("req_valid", 32'(imem_req_valid), 32'(want_valid));
    if (imem_req_valid) check("req_addr", imem_req_addr, fetch_model);
    if (rv && first_rsp < 0) first_rsp = cycle;
    if (out_valid && first_out < 0) first_out = cycle;
    if (pop && cycle >= win_lo && cycle < win_hi) pop_cnt++;

    if (rv) begin
      r = infl.pop_front();
      if (r.live && !redir) occ_model++;
    end
    if (redir) begin
      occ_model = 0;
      foreach (infl[i]) infl[i].live = 0;
      expq.delete();
      fetch_model = {redirect_pc[31:2], 2'b00};
    end else begin
      if (pop) occ_model--;
      if (hs) begin
        lat = $urandom_range(lat_max, lat_min);
        due = (cycle + lat > last_due + 1) ? cycle + lat : last_due + 1;
        last_due = due;
        infl.push_back('{addr: fetch_model, live: 1'b1, due: due});
        expq.push_back('{pc: fetch_model, instr: fetch_model ^ KEY});
        fetch_model = fetch_model + 32'd4;
      end
    end
    @(posedge clk);
    #1;
    cycle++;
    drive_inputs();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic check_reset_state();
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_occupancy", 32'(occupancy), 32'd0);
    check("rst_req_valid", 32'(imem_req_valid), 32'd0);
    check("rst_req_addr", imem_req_addr, RPC);
    check("rst_out_pc", out_pc, 32'd0);
    check("rst_out_instr", out_instr, 32'd0);
    check("rst_out_pc_plus4", out_pc_plus4, RPC + 32'd4);
  endtask

  task automatic reset_models_and_release();
    imem_rsp_valid = 1'b0;
    redirect_valid = 1'b0;
    infl.delete();
    expq.delete();
    occ_model   = 0;
    fetch_model = RPC;
    last_due    = -1;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst            = 1'b1;
    cycle          = 0;
    imem_req_ready = ($urandom_range(99) < p_rdy);
    out_ready      = ($urandom_range(99) < p_out);
  endtask

  initial begin
    tests = 0; fails = 0; cycle = 0;
    win_lo = 0; win_hi = 0; pop_cnt = 0; first_rsp = -1; first_out = -1;
    rst = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0; out_ready = 1'b0;
    #1;
    check_reset_state();

    // Streaming with single-cycle memory and an always-ready decode.
    lat_min = 1; lat_max = 1; p_rdy = 100; p_out = 100; p_redir = 0;
    win_lo = 5; win_hi = 35;
    reset_models_and_release();
    run(40);
    check("first_out_latency", 32'(first_out - first_rsp), 32'd1);
    check("throughput", 32'(pop_cnt), 32'd30);

    // Decode stalled: queue fills, fetch stops, then drains without loss.
    p_out = 0;
    run(20);
    check("full_occupancy", 32'(occupancy), 32'(DEPTH));
    check("full_no_request", 32'(imem_req_valid), 32'd0);
    p_out = 100;
    run(20);

    // Redirect with slow memory and requests in flight.
    lat_min = 3; lat_max = 3;
    run(10);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0103;
    step();
    check("redirect_addr", imem_req_addr, 32'h0000_0100);
    run(25);

    // Memory backpressure.
    lat_min = 1; lat_max = 2; p_rdy = 0;
    run(5);
    p_rdy = 100;
    run(10);

    // Random mix.
    lat_min = 1; lat_max = 4; p_rdy = 70; p_out = 60; p_redir = 8;
    run(2000);

    // Asynchronous reset mid-stream with the queue partly filled.
    lat_min = 3; lat_max = 3; p_rdy = 100; p_out = 0; p_redir = 0;
    run(6);
    #2;
    rst = 1'b0;
    #1;
    check_reset_state();
    lat_min = 1; lat_max = 3; p_out = 100;
    reset_models_and_release();
    check("post_reset_addr", imem_req_addr, RPC);
    run(30);

    // Frequent, often back-to-back redirects.
    lat_min = 1; lat_max = 4; p_rdy = 80; p_out = 70; p_redir = 35;
    run(1000);
    p_redir = 0; p_rdy = 100; p_out = 100;
    run(40);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
